control_cmd_readregion: RTL
===========================

# control_cmd_readregion

Parametrised successor to the full-frame read command. It consumes a byte stream from the command controller and writes it into frame RAM, either as a whole frame (mode FULL) or as a rectangular sub-region described by a 4-byte header (mode REGION). It sits between the command dispatcher and the frame-buffer write port, and drives the same row/column/pixel/data/write-enable/access-toggle interface as the existing frame-write commands.

## Interface
- PIXEL_WIDTH, params::PIXEL_WIDTH, columns per frame (≤256)
- PIXEL_HEIGHT, params::PIXEL_HEIGHT, rows per frame (≤256)
- BYTES_PER_PIXEL, params::BYTES_PER_PIXEL, bytes per pixel (≥1)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  a byte is presented on data_in; it is accepted on every posedge where enable=1
- data_in  in  8  stream byte
- mode  in  1  0=FULL, 1=REGION; sampled on the first accepted byte of a command
- row  out  types::row_addr_t  write row
- column  out  types::col_addr_t  write column
- pixel  out  types::pixel_addr_t  byte index within pixel
- data_out  out  8  write data
- ram_write_enable  out  1  write strobe
- ram_access_start  out  1  toggles once per write
- done  out  1  one-cycle completion pulse
- error  out  1  one-cycle pulse, coincident with done, when the region is out of range

## Operation
- States:
  - IDLE → HDR (REGION, first byte = x0) or PAYLOAD (FULL, first byte = payload 0 with x0=y0=0, w=PIXEL_WIDTH, h=PIXEL_HEIGHT).
  - HDR → PAYLOAD, DRAIN or DONE after the bytes x0, y0, w, h.
  - PAYLOAD/DRAIN → DONE after byte w·h·BYTES_PER_PIXEL.
  - DONE → IDLE after one cycle.
- Header checks use 9-bit arithmetic:
  - x0+w > PIXEL_WIDTH or y0+h > PIXEL_HEIGHT → DRAIN.
  - w=0 or h=0 → DONE directly, with zero writes and no error.
- Address order:
  - pixel is the fastest index, running 0..BYTES_PER_PIXEL-1;
  - then column, running x0..x0+w-1;
  - then row, running y0..y0+h-1.
  - Counters wrap to their start values; there is no modular wrap past the frame edge.
- DRAIN accepts the same byte count as PAYLOAD but keeps ram_write_enable low. It ends with done and error both asserted.
- enable low in any state: the state and the counters hold (stall), and ram_write_enable is 0 in the following cycle.
- Bytes presented in the DONE cycle are discarded. The controller must drop enable by then.
- Reset mid-operation → IDLE. All outputs return to their reset values. No partial-completion pulse.

## Timing
- Reset values: row=0, column=0, pixel=0, data_out=0, ram_write_enable=0, ram_access_start=0, done=0, error=0.
- Every output is registered.
- A payload byte accepted at edge N produces the following, visible from N until edge N+1:
  - data_out equals that byte;
  - the address is that byte's address;
  - ram_write_enable=1;
  - ram_access_start is inverted.
- A bench sampling at edge N+1 therefore sees data_out equal to the byte captured at edge N.
- Throughput: one write per clock while enable=1. There is no bubble between the header and the payload.
- The last payload or drain byte is accepted at edge L. done (and error, if applicable) is high for exactly the cycle after edge L+1.
- Empty region: the h byte is accepted at edge L; done is high for the cycle after edge L+1.

## Structure
- Shared package additions:
  - a cmd_mode_t enum (FULL, REGION);
  - a region_hdr_t struct with fields x0, y0, w, h, each 8 bits;
  - an elaboration assertion that PIXEL_WIDTH and PIXEL_HEIGHT are ≤256.
- One sub-module, region_addr_gen, holds the pixel/column/row counters with start/extent loading, an advance input and a last flag.
- The FSM and the output registers stay in the top module.

## Test plan
Directed tests assume a 64×32 frame with 2 bytes per pixel.

- FULL, 4096 bytes with value i&0xFF, enable continuous:
  - 4096 writes with ascending addresses;
  - data_out matches the byte captured one cycle earlier;
  - ram_access_start toggles every write;
  - done pulses once, error=0.
- REGION header (2,3,4,2), then 16 bytes:
  - exactly 16 writes;
  - first write at row3/col2/pix0, last at row4/col5/pix1;
  - done once.
- REGION header (62,0,4,1), then 8 bytes:
  - zero writes;
  - done and error pulse together after the 8th byte.
- REGION header (5,5,0,3):
  - no writes;
  - done pulses one cycle after the edge following the h byte;
  - a next command is accepted normally.
- Stall: enable low for 3 cycles mid-payload:
  - no writes during the gap;
  - the address resumes without skipping or duplicating;
  - total write count unchanged.
- Asynchronous reset asserted mid-payload:
  - outputs return to reset values immediately;
  - no done;
  - the following FULL command completes correctly.

Source files
------------

// File: rtl/control_cmd_readregion_pkg.sv
// Shared types and frame defaults for the region read command.
// Frame dimensions are checked at elaboration through frame_dims_ok().
package control_cmd_readregion_pkg;

    localparam int unsigned DEFAULT_PIXEL_WIDTH     = 64;
    localparam int unsigned DEFAULT_PIXEL_HEIGHT    = 32;
    localparam int unsigned DEFAULT_BYTES_PER_PIXEL = 2;

    typedef logic [7:0] row_addr_t;
    typedef logic [7:0] col_addr_t;
    typedef logic [7:0] pixel_addr_t;

    typedef enum logic {
        ModeFull   = 1'b0,
        ModeRegion = 1'b1
    } cmd_mode_t;

    typedef struct packed {
        logic [7:0] x0;
        logic [7:0] y0;
        logic [7:0] w;
        logic [7:0] h;
    } region_hdr_t;

    // Addresses are 8 bits wide, so a frame may span at most 256 columns/rows/bytes.
    function automatic bit frame_dims_ok(input int unsigned width, input int unsigned height,
                                         input int unsigned bpp);
        return (width >= 1) && (width <= 256) && (height >= 1) && (height <= 256) &&
               (bpp >= 1) && (bpp <= 256);
    endfunction

endpackage

// File: rtl/control_cmd_readregion_if.sv
// Byte-stream input and frame-RAM write port of the region read command.
interface control_cmd_readregion_if;
    import control_cmd_readregion_pkg::*;

    logic        enable;
    logic [7:0]  data_in;
    logic        mode;
    row_addr_t   row;
    col_addr_t   column;
    pixel_addr_t pixel;
    logic [7:0]  data_out;
    logic        ram_write_enable;
    logic        ram_access_start;
    logic        done;
    logic        error;

    modport master (
        output enable, data_in, mode,
        input  row, column, pixel, data_out, ram_write_enable, ram_access_start, done, error
    );

    modport slave (
        input  enable, data_in, mode,
        output row, column, pixel, data_out, ram_write_enable, ram_access_start, done, error
    );

endinterface

// File: rtl/control_cmd_readregion_region_addr_gen.sv
// Pixel/column/row counters for a rectangular write region; pixel is the fastest index.
// On load the start address is presented in the same cycle, so load and advance may coincide.
module region_addr_gen
    import control_cmd_readregion_pkg::*;
#(
    parameter int unsigned BYTES_PER_PIXEL = DEFAULT_BYTES_PER_PIXEL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  col_addr_t   start_col,
    input  row_addr_t   start_row,
    input  logic [8:0]  width,
    input  logic [8:0]  height,
    input  logic        advance,
    output pixel_addr_t pixel,
    output col_addr_t   column,
    output row_addr_t   row,
    output logic        last
);

    localparam logic [8:0] PixLast = 9'(BYTES_PER_PIXEL - 1);

    // Nine-bit counters so out-of-frame regions still count w*h*bpp bytes correctly.
    logic [8:0] pix_q, pix_d, col_q, col_d, row_q, row_d;
    logic [8:0] col_first_q, col_first_d, row_first_q, row_first_d;
    logic [8:0] col_last_q, col_last_d, row_last_q, row_last_d;
    logic [8:0] pix_b, col_b, row_b;
    logic       pix_end, col_end, row_end;

    always_comb begin
        col_first_d = load ? {1'b0, start_col} : col_first_q;
        row_first_d = load ? {1'b0, start_row} : row_first_q;
        col_last_d  = load ? {1'b0, start_col} + width - 9'd1 : col_last_q;
        row_last_d  = load ? {1'b0, start_row} + height - 9'd1 : row_last_q;

        pix_b = load ? 9'd0 : pix_q;
        col_b = load ? col_first_d : col_q;
        row_b = load ? row_first_d : row_q;

        pix_end = (pix_b == PixLast);
        col_end = (col_b == col_last_d);
        row_end = (row_b == row_last_d);
        last    = pix_end && col_end && row_end;

        pix_d = pix_b;
        col_d = col_b;
        row_d = row_b;
        if (advance) begin
            if (!pix_end) begin
                pix_d = pix_b + 9'd1;
            end else begin
                pix_d = 9'd0;
                if (!col_end) begin
                    col_d = col_b + 9'd1;
                end else begin
                    col_d = col_first_d;
                    row_d = row_end ? row_first_d : row_b + 9'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            col_first_q <= '0;
            row_first_q <= '0;
            col_last_q  <= '0;
            row_last_q  <= '0;
        end else begin
            pix_q       <= pix_d;
            col_q       <= col_d;
            row_q       <= row_d;
            col_first_q <= col_first_d;
            row_first_q <= row_first_d;
            col_last_q  <= col_last_d;
            row_last_q  <= row_last_d;
        end
    end

    assign pixel  = pix_b[7:0];
    assign column = col_b[7:0];
    assign row    = row_b[7:0];

endmodule

// File: rtl/control_cmd_readregion.sv
// Frame or sub-region write command: turns a byte stream into frame-RAM writes.
// FSM and all output registers live here; region_addr_gen supplies the addresses.
module control_cmd_readregion
    import control_cmd_readregion_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH     = DEFAULT_PIXEL_WIDTH,
    parameter int unsigned PIXEL_HEIGHT    = DEFAULT_PIXEL_HEIGHT,
    parameter int unsigned BYTES_PER_PIXEL = DEFAULT_BYTES_PER_PIXEL
) (
    input logic                     clk,
    input logic                     reset,
    control_cmd_readregion_if.slave bus
);

    if (!frame_dims_ok(PIXEL_WIDTH, PIXEL_HEIGHT, BYTES_PER_PIXEL)) begin : g_dim_check
        $fatal(1, "control_cmd_readregion: frame dimensions out of range");
    end

    typedef enum logic [2:0] {StIdle, StHdr, StPayload, StDrain, StDone} state_t;

    state_t      state_q, state_d;
    region_hdr_t hdr_q, hdr_d;
    logic [1:0]  hdr_idx_q, hdr_idx_d;
    logic        drain_q, drain_d;

    row_addr_t   row_q;
    col_addr_t   col_q;
    pixel_addr_t pix_q;
    logic [7:0]  data_q;
    logic        we_q, toggle_q, done_q, error_q;

    logic        is_full_start, hdr_final, gen_load, gen_advance, wr_fire, gen_last;
    col_addr_t   load_col, gen_col;
    row_addr_t   load_row, gen_row;
    pixel_addr_t gen_pix;
    logic [8:0]  load_w, load_h, hdr_x_end, hdr_y_end;

    // Kept separate from the FSM block so gen_last never feeds back into gen_load.
    assign is_full_start = (state_q == StIdle) && (cmd_mode_t'(bus.mode) == ModeFull);
    assign hdr_final     = (state_q == StHdr) && (hdr_idx_q == 2'd3);
    assign gen_load      = bus.enable && (is_full_start || hdr_final);
    assign gen_advance   = bus.enable &&
                           (is_full_start || state_q == StPayload || state_q == StDrain);
    assign wr_fire       = bus.enable && (is_full_start || state_q == StPayload);

    assign load_col = is_full_start ? '0 : hdr_q.x0;
    assign load_row = is_full_start ? '0 : hdr_q.y0;
    assign load_w   = is_full_start ? 9'(PIXEL_WIDTH) : {1'b0, hdr_q.w};
    assign load_h   = is_full_start ? 9'(PIXEL_HEIGHT) : {1'b0, bus.data_in};

    assign hdr_x_end = {1'b0, hdr_q.x0} + {1'b0, hdr_q.w};
    assign hdr_y_end = {1'b0, hdr_q.y0} + {1'b0, bus.data_in};

    region_addr_gen #(
        .BYTES_PER_PIXEL (BYTES_PER_PIXEL)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (gen_load),
        .start_col (load_col),
        .start_row (load_row),
        .width     (load_w),
        .height    (load_h),
        .advance   (gen_advance),
        .pixel     (gen_pix),
        .column    (gen_col),
        .row       (gen_row),
        .last      (gen_last)
    );

    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        hdr_idx_d = hdr_idx_q;
        drain_d   = drain_q;
        unique case (state_q)
            StIdle: begin
                if (bus.enable) begin
                    drain_d = 1'b0;
                    if (cmd_mode_t'(bus.mode) == ModeRegion) begin
                        hdr_d.x0  = bus.data_in;
                        hdr_idx_d = 2'd1;
                        state_d   = StHdr;
                    end else begin
                        state_d = gen_last ? StDone : StPayload;
                    end
                end
            end
            StHdr: begin
                if (bus.enable) begin
                    hdr_idx_d = hdr_idx_q + 2'd1;
                    case (hdr_idx_q)
                        2'd1: hdr_d.y0 = bus.data_in;
                        2'd2: hdr_d.w  = bus.data_in;
                        default: begin
                            hdr_d.h = bus.data_in;
                            if (hdr_q.w == 8'd0 || bus.data_in == 8'd0) begin
                                state_d = StDone;
                            end else if (hdr_x_end > 9'(PIXEL_WIDTH) ||
                                         hdr_y_end > 9'(PIXEL_HEIGHT)) begin
                                drain_d = 1'b1;
                                state_d = StDrain;
                            end else begin
                                state_d = StPayload;
                            end
                        end
                    endcase
                end
            end
            StPayload, StDrain: begin
                if (bus.enable && gen_last) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            hdr_q     <= '0;
            hdr_idx_q <= '0;
            drain_q   <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            pix_q     <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            toggle_q  <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_q     <= hdr_d;
            hdr_idx_q <= hdr_idx_d;
            drain_q   <= drain_d;
            we_q      <= wr_fire;
            done_q    <= (state_q == StDone);
            error_q   <= (state_q == StDone) && drain_q;
            if (wr_fire) begin
                row_q    <= gen_row;
                col_q    <= gen_col;
                pix_q    <= gen_pix;
                data_q   <= bus.data_in;
                toggle_q <= ~toggle_q;
            end
        end
    end

    assign bus.row              = row_q;
    assign bus.column           = col_q;
    assign bus.pixel            = pix_q;
    assign bus.data_out         = data_q;
    assign bus.ram_write_enable = we_q;
    assign bus.ram_access_start = toggle_q;
    assign bus.done             = done_q;
    assign bus.error            = error_q;

endmodule
